// File: rtl/conv_pkg.sv
// Shared types and defaults for the 3x3 sliding-window generator and the conv layers it feeds.
package conv_pkg;

  localparam int DEF_W     = 16;
  localparam int DEF_LANES = 8;
  localparam int DEF_FM_H  = 13;
  localparam int DEF_FM_W  = 13;

  typedef logic [DEF_W-1:0] pix_t;
  typedef pix_t [DEF_LANES-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } wingen_state_e;

  // (s + k) mod 3 for the rotating row-buffer slot index.
  function automatic logic [1:0] slot_inc(input logic [1:0] s, input logic [1:0] k);
    logic [2:0] t;
    t = {1'b0, s} + {1'b0, k};
    return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  endfunction

endpackage

// File: rtl/wingen_row_buf.sv
// One feature-map row (FM_W pixels of LANES x W bits) with a single write port and
// three combinational read taps at col-1, col, col+1; taps outside the row read zero.
module wingen_row_buf #(
  parameter int W     = 16,
  parameter int LANES = 8,
  parameter int FM_W  = 13,
  localparam int CW   = $clog2(FM_W),
  localparam int LW   = LANES * W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] wr_col,
  input  logic [LW-1:0] wr_data,
  input  logic [CW-1:0] rd_col,
  output logic [LW-1:0] tap_l,
  output logic [LW-1:0] tap_c,
  output logic [LW-1:0] tap_r
);

  localparam logic [CW-1:0] LAST_COL = CW'(FM_W - 1);

  logic [LW-1:0] mem [FM_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_col] <= wr_data;
  end

  always_comb begin
    tap_l = (rd_col == '0)       ? '0 : mem[rd_col - CW'(1)];
    tap_c = mem[rd_col];
    tap_r = (rd_col == LAST_COL) ? '0 : mem[rd_col + CW'(1)];
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 zero-padded window generator over three rotating row buffers.
// Optional in_last framing check enabled by defining CONV_WINGEN_FRAME_CHECK_EN.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LANES = DEF_LANES,
  parameter int FM_H  = DEF_FM_H,
  parameter int FM_W  = DEF_FM_W,
  localparam int RW   = $clog2(FM_H),
  localparam int CW   = $clog2(FM_W),
  localparam int LW   = LANES * W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LW-1:0]   in_data,
  input  logic            in_last,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*LW-1:0] win_data,
  output logic [RW-1:0]   win_row,
  output logic [CW-1:0]   win_col,
  output logic            win_last,
  output logic            frame_err
);

  // Handshake: a beat transfers on a rising edge where valid && ready; valid and
  // the payload are driven from registered state only and hold until accepted.

  localparam logic [RW-1:0] LAST_ROW = RW'(FM_H - 1);
  localparam logic [RW-1:0] PEN_ROW  = RW'(FM_H - 2);
  localparam logic [CW-1:0] LAST_COL = CW'(FM_W - 1);

  wingen_state_e state;
  logic [RW-1:0] in_row, emit_row;
  logic [CW-1:0] in_col, emit_col;
  logic [1:0]    in_slot, emit_slot;
  logic          in_fire, win_fire;
  logic [LW-1:0] taps [3][3];
  logic [1:0]    row_slot [3];
  logic          row_ok [3];

  assign in_ready  = (state == ST_LOAD);
  assign win_valid = (state == ST_EMIT);
  assign in_fire   = in_valid && in_ready;
  assign win_fire  = win_valid && win_ready;
  assign win_row   = emit_row;
  assign win_col   = emit_col;
  assign win_last  = win_valid && (emit_row == LAST_ROW) && (emit_col == LAST_COL);

  for (genvar s = 0; s < 3; s++) begin : g_slot
    wingen_row_buf #(.W(W), .LANES(LANES), .FM_W(FM_W)) u_buf (
      .clk     (clk),
      .we      (in_fire && (in_slot == 2'(s))),
      .wr_col  (in_col),
      .wr_data (in_data),
      .rd_col  (emit_col),
      .tap_l   (taps[s][0]),
      .tap_c   (taps[s][1]),
      .tap_r   (taps[s][2])
    );
  end

  // Row above lives two slots on (mod 3), row below one slot on.
  always_comb begin
    row_slot[0] = slot_inc(emit_slot, 2'd2);
    row_slot[1] = emit_slot;
    row_slot[2] = slot_inc(emit_slot, 2'd1);
    row_ok[0]   = (emit_row != '0);
    row_ok[1]   = 1'b1;
    row_ok[2]   = (emit_row != LAST_ROW);
    win_data    = '0;
    if (state == ST_EMIT) begin
      for (int dy = 0; dy < 3; dy++) begin
        if (row_ok[dy]) begin
          for (int dx = 0; dx < 3; dx++) begin
            win_data[(dy*3+dx)*LW +: LW] = taps[row_slot[dy]][dx];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_row    <= '0;
      in_col    <= '0;
      in_slot   <= 2'd0;
      emit_row  <= '0;
      emit_col  <= '0;
      emit_slot <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_LOAD;
        ST_LOAD: begin
          if (in_fire) begin
            if (in_col == LAST_COL) begin
              in_col <= '0;
              if (in_row == LAST_ROW) begin
                in_row  <= '0;
                in_slot <= 2'd0;
              end else begin
                in_row  <= in_row + RW'(1);
                in_slot <= slot_inc(in_slot, 2'd1);
              end
              // Row 0 alone never completes a load; every later row is a load target.
              if (in_row != '0) state <= ST_EMIT;
            end else begin
              in_col <= in_col + CW'(1);
            end
          end
        end
        ST_EMIT: begin
          if (win_fire) begin
            if (emit_col == LAST_COL) begin
              emit_col <= '0;
              if (emit_row == LAST_ROW) begin
                emit_row  <= '0;
                emit_slot <= 2'd0;
                state     <= ST_LOAD;
              end else begin
                emit_row  <= emit_row + RW'(1);
                emit_slot <= slot_inc(emit_slot, 2'd1);
                if (emit_row != PEN_ROW) state <= ST_LOAD;
              end
            end else begin
              emit_col <= emit_col + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CONV_WINGEN_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (in_fire && (in_last != ((in_row == LAST_ROW) && (in_col == LAST_COL)))) begin
      frame_err <= 1'b1;
    end
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign frame_err      = 1'b0;
`endif

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator that feeds the 3x3 convolution layers, such as the 13x13 conv3 stage. It accepts a feature map one pixel per beat in raster order, with LANES channels per beat, and stores it in three rotating row buffers. It then emits every 3x3 neighbourhood, zero-padded at the borders (padding 1, stride 1), as a valid/ready stream consumed by the conv/ReLU datapath. It replaces whole-image parallel input buses with a buffered, back-pressured producer.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Parameters:
  - `W`, 16: bits per channel value (Q-format as in conv layers)
  - `LANES`, 8: channels carried per pixel beat
  - `FM_H`, 13: feature-map rows
  - `FM_W`, 13: feature-map columns
- Ports:
  - `clk`  in  1  rising-edge clock
  - `rst_n`  in  1  async active-low reset
  - `in_valid`  in  1  input pixel valid
  - `in_ready`  out  1  block accepts pixel
  - `in_data`  in  LANES×W  pixel, lane 0 = lowest channel
  - `in_last`  in  1  marks final pixel of frame (checked only with macro)
  - `win_valid`  out  1  window valid
  - `win_ready`  in  1  consumer accepts window
  - `win_data`  out  3×3×LANES×W  window [dy][dx][lane], dy/dx 0..2, centre at [1][1]
  - `win_row`  out  $clog2(FM_H)  centre row
  - `win_col`  out  $clog2(FM_W)  centre column
  - `win_last`  out  1  window (FM_H-1, FM_W-1)
  - `frame_err`  out  1  sticky in_last mismatch flag

## Operation
- FSM states: IDLE, LOAD, EMIT.
- Reset → IDLE. Next cycle → LOAD with load target row 1.
- LOAD:
  - `in_ready`=1. Each in_valid&&in_ready beat writes buffer slot (row mod 3), column = input column counter.
  - Column wraps at FM_W-1 and increments the input row.
  - When the target row completes → EMIT.
- EMIT:
  - `in_ready`=0, `win_valid`=1. Centre row r, column c runs 0..FM_W-1.
  - Taps come from slots (r-1, r, r+1) mod 3. A tap with row <0, row ≥FM_H, col <0 or col ≥FM_W reads 0.
  - Each win_valid&&win_ready beat advances c.
  - After c=FM_W-1: if r+1 < FM_H-1, go to LOAD with target r+2. If r+1 = FM_H-1, stay in EMIT with r+1; no load is needed. If r = FM_H-1, the frame is done: go to LOAD, target row 1, counters cleared.
- Slot reuse: loading row r+2 overwrites slot of row r-1, which is no longer needed.
- Per frame: FM_H×FM_W input beats accepted and FM_H×FM_W windows emitted, in raster order of centre.
- Back-to-back frames are allowed. The first pixel of frame n+1 is accepted the cycle after frame n's win_last handshake.

## Timing
- Reset values: in_ready=0, win_valid=0, win_last=0, win_row=0, win_col=0, frame_err=0, win_data=0. Row buffer contents are not reset.
- Outputs decode from registered state and counters only. There are no combinational paths from in_valid or win_ready to any output.
- First window: win_valid rises the cycle after the 2·FM_W-th pixel is accepted.
- Stall rule: while win_valid && !win_ready, win_data, win_row, win_col and win_last hold stable.
- Async reset mid-frame: all state, counters and frame_err clear immediately. The partial frame is discarded and the next accepted pixel is row 0, col 0.
- Throughput: 1 beat/cycle in each phase. Load and emit do not overlap.

## Configuration
- `CONV_WINGEN_FRAME_CHECK_EN`
  - Defined: frame_err sets (sticky until reset) when in_last=1 on a non-final accepted pixel, or in_last=0 on the final pixel (row FM_H-1, col FM_W-1). Data flow is unaffected.
  - Undefined: in_last is ignored and frame_err is tied 0.

## Structure
- Shared package `conv_pkg`:
  - `pix_t` (logic [W-1:0])
  - `FM_H`/`FM_W` defaults
  - lane-vector typedef
  - FSM state enum `wingen_state_e`
- Sub-module `wingen_row_buf`: one FM_W×LANES×W row store with one write port and three combinational read taps (col-1, col, col+1, out-of-range → 0). It is instantiated three times.

## Test plan
- Single frame, pixel (r,c) lane l = r·16+c+l·256, win_ready=1 → 169 windows in raster order. Window (5,5) [0][0] lane 0 = 0x44. win_last only on (12,12).
- Borders: window (0,0) has row dy=0 and column dx=0 all zero, and [1][1] lane 0 = 0x000. Window (12,12) has dy=2 and dx=2 zero.
- Backpressure: win_ready random 30% low → identical window sequence. Outputs stable during each stall. No input accepted during EMIT.
- Two back-to-back frames with distinct data → 338 windows, second frame fully correct, and in_ready high the cycle after first win_last.
- With macro: in_last asserted on pixel 100 → frame_err=1 from next cycle and held. Without macro → frame_err stays 0.
- rst_n pulsed low mid-EMIT of row 4 → all outputs 0 immediately. A fresh full frame afterwards yields correct 169 windows.
